button_debounce_array: RTL
==========================

BUTTON_DEBOUNCE_ARRAY -- requirements
Module: button_debounce_array

Interface
REQ-001 Parameter CH, default 4: number of independent button channels (1..32).
REQ-002 Parameter CNT_W, default 11: width of the per-channel debounce counter and of the deb_thr input.
REQ-003 Parameter LONG_W, default 16: width of the per-channel hold counter and of the long_thr input.
REQ-004 Parameter ACTIVE_LOW, default 0: when 1, btn_in bits are inverted before synchronisation, so a pressed button reads as 1 internally.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 n_reset  input  1  synchronous, active-low reset.
REQ-007 btn_in  input  CH  raw, asynchronous button levels.
REQ-008 deb_thr  input  CNT_W  number of consecutive mismatch cycles required to accept a new level; quasi-static.
REQ-009 long_thr  input  LONG_W  hold cycles after a debounced press before a long press is flagged; 0 disables long-press detection.
REQ-010 db_out  output  CH  debounced level per channel (registered).
REQ-011 rise_p  output  CH  one-cycle pulse when db_out goes 0->1.
REQ-012 fall_p  output  CH  one-cycle pulse when db_out goes 1->0.
REQ-013 long_p  output  CH  one-cycle pulse when a long press is first detected.
REQ-014 long_lvl  output  CH  level; 1 from long detection until db_out falls.
REQ-015 any_evt  output  1  registered OR of rise_p, fall_p and long_p across all channels.

Function
REQ-016 Each channel SHALL pass through a two-flop synchroniser (s1 <= btn_in after optional inversion; s2 <= s1), with no cross-channel logic except any_evt.
REQ-017 The effective threshold SHALL be thr_e = max(deb_thr, 1).
REQ-018 When s2 == db_out, the channel counter SHALL clear to 0 on the next edge, so any bounce back to the stable level restarts the count.
REQ-019 When s2 != db_out and cnt+1 >= thr_e, the next edge SHALL set db_out <= s2 and cnt <= 0; otherwise it SHALL set cnt <= cnt+1.
REQ-020 Because the comparison is >=, lowering deb_thr below the current count SHALL cause acceptance on the next mismatch cycle; the counter SHALL never wrap.
REQ-021 Latency: a clean btn_in step first sampled at edge e SHALL change db_out at edge e+1+thr_e.
REQ-022 rise_p and fall_p SHALL assert on the same edge db_out changes and SHALL deassert on the following edge.
REQ-023 The hold counter SHALL clear while db_out == 0.
REQ-024 While db_out == 1, the hold counter SHALL increment each cycle, saturating at all-ones.
REQ-025 When long_thr != 0 and the incremented hold count first equals long_thr, long_p SHALL pulse for one cycle and long_lvl SHALL set.
REQ-026 long_lvl SHALL clear on the edge db_out falls, coincident with fall_p.
REQ-027 Saturation SHALL NOT retrigger long_p; a long_thr change after detection SHALL NOT retrigger it within the same press.
REQ-028 any_evt SHALL be registered one cycle after the corresponding pulse edge.
REQ-029 Simultaneous events on several channels SHALL each be reported in their own bit with no priority or loss.

Reset
REQ-030 While n_reset == 0 at an edge, s1, s2, all counters, db_out, rise_p, fall_p, long_p, long_lvl and any_evt SHALL be 0.
REQ-031 Reset asserted mid-count or mid-press SHALL abort the count or press without emitting any pulse.
REQ-032 After reset release, a button already held SHALL be accepted as a fresh press after the normal latency, including rise_p.

Verification
REQ-033 deb_thr=4, btn_in[0] steps 0->1 sampled at edge 10 -> db_out[0]=1 and rise_p[0]=1 at edge 15, rise_p[0]=0 at edge 16, any_evt=1 at edge 16.
REQ-034 deb_thr=4, btn_in[1] toggles 1,0,1,0 on successive edges, then holds 1 -> no output change during toggling; db_out[1] rises 4 mismatch cycles after the final transition is synchronised.
REQ-035 deb_thr=2, long_thr=10, press held -> long_p pulses exactly once 10 cycles after rise_p and long_lvl holds; on release long_lvl clears with fall_p.
REQ-036 deb_thr=0 -> behaves as deb_thr=1, with db_out following btn_in 2 edges later; long_thr=0 with a long hold -> long_p never asserts.
REQ-037 Channels 0 and 3 pressed on the same edge -> rise_p=4'b1001 on one edge; n_reset pulsed low mid-hold -> all outputs 0, no fall_p, and rise_p reissued after release.
REQ-038 ACTIVE_LOW=1, btn_in idle all-ones after reset -> db_out stays 0 and no pulses are emitted.

Source files
------------

// File: rtl/button_debounce_array.sv
// button_debounce_array: per-channel synchronise, debounce, edge and long-press detection
module button_debounce_array #(
    parameter int CH         = 4,
    parameter int CNT_W      = 11,
    parameter int LONG_W     = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [CH-1:0]     btn_in,
    input  logic [CNT_W-1:0]  deb_thr,
    input  logic [LONG_W-1:0] long_thr,
    output logic [CH-1:0]     db_out,
    output logic [CH-1:0]     rise_p,
    output logic [CH-1:0]     fall_p,
    output logic [CH-1:0]     long_p,
    output logic [CH-1:0]     long_lvl,
    output logic              any_evt
);
    logic [CH-1:0] s1, s2;
    logic [CNT_W:0] thr_e;
    assign thr_e = (deb_thr == '0) ? (CNT_W+1)'(1) : {1'b0, deb_thr};
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1 <= '0;
            s2 <= '0;
            any_evt <= 1'b0;
        end else begin
            s1 <= btn_in ^ {CH{ACTIVE_LOW}};
            s2 <= s1;
            any_evt <= |(rise_p | fall_p | long_p);
        end
    end
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [LONG_W-1:0] hold;
        logic [CNT_W:0] cnt_inc;
        logic db_r, rise_r, fall_r, long_r, lvl_r;
        logic mism, accept, hold_sat, long_hit;
        assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
        assign mism = s2[i] ^ db_r;
        assign accept = mism && (cnt_inc >= thr_e);
        assign hold_sat = &hold;
        // lvl_r latches detection so a later long_thr change cannot retrigger this press
        assign long_hit = db_r && !accept && !lvl_r && (long_thr != '0) && !hold_sat &&
                          (hold + LONG_W'(1) == long_thr);
        always_ff @(posedge clk) begin
            if (!n_reset) begin
                cnt <= '0;
                hold <= '0;
                db_r <= 1'b0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                long_r <= 1'b0;
                lvl_r <= 1'b0;
            end else begin
                cnt <= (mism && !accept) ? cnt_inc[CNT_W-1:0] : '0;
                hold <= !db_r ? '0 : hold_sat ? hold : hold + LONG_W'(1);
                db_r <= db_r ^ accept;
                rise_r <= accept && s2[i];
                fall_r <= accept && !s2[i];
                long_r <= long_hit;
                lvl_r <= accept ? 1'b0 : (lvl_r | long_hit);
            end
        end
        assign db_out[i] = db_r;
        assign rise_p[i] = rise_r;
        assign fall_p[i] = fall_r;
        assign long_p[i] = long_r;
        assign long_lvl[i] = lvl_r;
    end
endmodule
